// File: rtl/param_cam_engine.sv
// Parametrised ternary CAM with per-entry valid bits, lowest-index priority encoding,
// hit counting, invalidate, synchronous flush and an occupancy counter.
module param_cam_engine #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        op,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mask,
  output logic              rsp_valid,
  output logic              hit,
  output logic              multi_hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  match;
  logic [CNT_W-1:0]  occupancy_reg;
  logic              rsp_valid_reg;
  logic              hit_reg;
  logic              multi_hit_reg;
  logic [ADDR_W-1:0] hit_addr_reg;
  logic [CNT_W-1:0]  hit_count_reg;
  logic [ADDR_W-1:0] first_addr_next;
  logic [CNT_W-1:0]  match_count_next;
  logic              addr_ok;
  logic              do_write;
  logic              do_inval;

  // Only non-power-of-two depths can see an out-of-range address.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_addr_pow2
      assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
      assign addr_ok = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] & (((mem[gi] ^ data) & mask) == '0);
    end
  endgenerate

  // Reverse scan so the lowest matching index wins.
  always_comb begin
    first_addr_next  = '0;
    match_count_next = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) first_addr_next = ADDR_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      match_count_next = match_count_next + CNT_W'(match[i]);
    end
  end

  assign do_write = ena && !flush && (op == OP_WRITE) && addr_ok;
  assign do_inval = ena && !flush && (op == OP_INVAL) && addr_ok;

  // Word storage carries no reset; valid bits alone decide whether it is live.
  always_ff @(posedge clk) begin
    if (rst_n && do_write) mem[addr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= '0;
      occupancy_reg <= '0;
      rsp_valid_reg <= 1'b0;
      hit_reg       <= 1'b0;
      multi_hit_reg <= 1'b0;
      hit_addr_reg  <= '0;
      hit_count_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (ena) begin
        if (flush) begin
          valid_reg     <= '0;
          occupancy_reg <= '0;
          hit_reg       <= 1'b0;
          multi_hit_reg <= 1'b0;
          hit_addr_reg  <= '0;
          hit_count_reg <= '0;
        end else begin
          case (op)
            OP_SEARCH: begin
              rsp_valid_reg <= 1'b1;
              hit_reg       <= (match_count_next != '0);
              multi_hit_reg <= (match_count_next > CNT_W'(1));
              hit_addr_reg  <= first_addr_next;
              hit_count_reg <= match_count_next;
            end
            OP_WRITE: begin
              if (do_write) begin
                valid_reg[addr] <= 1'b1;
                if (!valid_reg[addr]) occupancy_reg <= occupancy_reg + CNT_W'(1);
              end
            end
            OP_INVAL: begin
              if (do_inval && valid_reg[addr]) begin
                valid_reg[addr] <= 1'b0;
                occupancy_reg   <= occupancy_reg - CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign hit       = hit_reg;
  assign multi_hit = multi_hit_reg;
  assign hit_addr  = hit_addr_reg;
  assign hit_count = hit_count_reg;
  assign occupancy = occupancy_reg;
  assign full      = (occupancy_reg == CNT_W'(DEPTH));

endmodule

// File: tb/tb_param_cam_engine.sv
// Self-checking bench for param_cam_engine: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_param_cam_engine;

  localparam int DW = 8;
  localparam int DP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] op;
  logic       flush;
  logic [3:0] addr;
  logic [7:0] data;
  logic [7:0] mask;
  logic       rsp_valid, hit, multi_hit, full;
  logic [3:0] hit_addr;
  logic [4:0] hit_count, occupancy;

  param_cam_engine #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .op(op), .flush(flush), .addr(addr),
    .data(data), .mask(mask), .rsp_valid(rsp_valid), .hit(hit), .multi_hit(multi_hit),
    .hit_addr(hit_addr), .hit_count(hit_count), .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: plain arrays plus the last reported search result.
  logic [7:0] m_mem [DP];
  bit         m_valid [DP];
  bit         e_rsp, e_hit, e_multi;
  int         e_addr, e_cnt;

  logic [17:0] obs_vec;
  assign obs_vec = {rsp_valid, hit, multi_hit, hit_addr, hit_count, occupancy, full};

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < DP; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic logic [17:0] model_vec();
    int o = model_occ();
    return {e_rsp, e_hit, e_multi, 4'(e_addr), 5'(e_cnt), 5'(o), (o == DP)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_valid[i] = 0;
    e_rsp = 0; e_hit = 0; e_multi = 0; e_addr = 0; e_cnt = 0;
  endtask

  task automatic model_step(input bit e, input bit f, input int o, input int a,
                            input logic [7:0] d, input logic [7:0] m);
    e_rsp = 0;
    if (!e) return;
    if (f) begin
      for (int i = 0; i < DP; i++) m_valid[i] = 0;
      e_hit = 0; e_multi = 0; e_addr = 0; e_cnt = 0;
    end else if (o == 1) begin
      int cnt = 0;
      int low = -1;
      for (int i = 0; i < DP; i++)
        if (m_valid[i] && (((m_mem[i] ^ d) & m) == 8'h00)) begin
          cnt++;
          if (low < 0) low = i;
        end
      e_rsp = 1; e_hit = (cnt >= 1); e_multi = (cnt >= 2);
      e_addr = (low < 0) ? 0 : low; e_cnt = cnt;
    end else if (o == 2) begin
      m_mem[a] = d; m_valid[a] = 1;
    end else if (o == 3) begin
      m_valid[a] = 0;
    end
  endtask

  task automatic drive(input bit e, input bit f, input int o, input int a,
                       input logic [7:0] d, input logic [7:0] m);
    @(negedge clk);
    ena = e; flush = f; op = 2'(o); addr = 4'(a); data = d; mask = m;
    @(posedge clk);
    model_step(e, f, o, a, d, m);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; flush = 1'b0; op = 2'b00; addr = '0; data = '0; mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs_vec !== 18'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs_vec, 18'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset: outputs %h", obs_vec);
  endtask

  task automatic test_directed();
    logic [17:0] snap;
    // Scenario 1
    drive(1, 0, 2, 0, 8'h55, 8'hFF);
    drive(1, 0, 2, 1, 8'hAA, 8'hFF);
    drive(1, 0, 2, 2, 8'h77, 8'hFF);
    drive(1, 0, 2, 15, 8'h33, 8'hFF);
    drive(1, 0, 1, 0, 8'h77, 8'hFF);
    n_vec++;
    if ({rsp_valid, hit, hit_addr, hit_count, occupancy} !== {1'b1, 1'b1, 4'd2, 5'd1, 5'd4}) begin
      n_bad++; $display("FAIL search_77: got %h want %h",
        {rsp_valid, hit, hit_addr, hit_count, occupancy}, {1'b1, 1'b1, 4'd2, 5'd1, 5'd4});
    end
    $display("search 77: rsp=%0d hit=%0d addr=%0d cnt=%0d occ=%0d", rsp_valid, hit, hit_addr, hit_count, occupancy);
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    n_vec++;
    if ({rsp_valid, hit, hit_addr} !== {1'b0, 1'b1, 4'd2}) begin
      n_bad++; $display("FAIL rsp_pulse_hold: got %h want %h", {rsp_valid, hit, hit_addr}, {1'b0, 1'b1, 4'd2});
    end
    // Scenario 2
    drive(1, 0, 1, 0, 8'hFF, 8'hFF);
    n_vec++;
    if ({rsp_valid, hit, multi_hit, hit_addr, hit_count} !== {3'b100, 4'd0, 5'd0}) begin
      n_bad++; $display("FAIL miss_FF: got %h want %h", {rsp_valid, hit, multi_hit, hit_addr, hit_count}, {3'b100, 4'd0, 5'd0});
    end
    drive(1, 0, 1, 0, 8'h00, 8'hFF);
    n_vec++;
    if ({rsp_valid, hit, multi_hit, hit_addr, hit_count} !== {3'b100, 4'd0, 5'd0}) begin
      n_bad++; $display("FAIL miss_00: got %h want %h", {rsp_valid, hit, multi_hit, hit_addr, hit_count}, {3'b100, 4'd0, 5'd0});
    end
    $display("search FF/00: hit=%0d cnt=%0d", hit, hit_count);
    // Scenario 3
    drive(1, 0, 2, 3, 8'h5A, 8'hFF);
    drive(1, 0, 2, 9, 8'h5F, 8'hFF);
    drive(1, 0, 1, 0, 8'h50, 8'hF0);
    n_vec++;
    if ({hit, multi_hit, hit_addr, hit_count} !== {2'b11, 4'd0, 5'd3}) begin
      n_bad++; $display("FAIL ternary_5x: got %h want %h", {hit, multi_hit, hit_addr, hit_count}, {2'b11, 4'd0, 5'd3});
    end
    $display("ternary 5x: multi=%0d addr=%0d cnt=%0d", multi_hit, hit_addr, hit_count);
    // Scenario 4
    drive(1, 0, 2, 1, 8'hCC, 8'hFF);
    n_vec++;
    if (occupancy !== 5'd6) begin
      n_bad++; $display("FAIL overwrite_occ: got %0d want %0d", occupancy, 6);
    end
    drive(1, 0, 1, 0, 8'hAA, 8'hFF);
    n_vec++;
    if (hit !== 1'b0) begin
      n_bad++; $display("FAIL overwritten_gone: got %0d want %0d", hit, 0);
    end
    drive(1, 0, 1, 0, 8'hCC, 8'hFF);
    n_vec++;
    if ({hit, hit_addr} !== {1'b1, 4'd1}) begin
      n_bad++; $display("FAIL overwrite_found: got %h want %h", {hit, hit_addr}, {1'b1, 4'd1});
    end
    $display("overwrite: occ=%0d addr=%0d", occupancy, hit_addr);
    // Scenario 5
    drive(1, 0, 3, 0, 8'h00, 8'h00);
    drive(1, 0, 3, 0, 8'h00, 8'h00);
    n_vec++;
    if (occupancy !== 5'd5) begin
      n_bad++; $display("FAIL double_inval: got %0d want %0d", occupancy, 5);
    end
    drive(1, 0, 1, 0, 8'h55, 8'hFF);
    n_vec++;
    if ({rsp_valid, hit} !== 2'b10) begin
      n_bad++; $display("FAIL inval_miss: got %b want %b", {rsp_valid, hit}, 2'b10);
    end
    // Flush alongside a WRITE: the op must be ignored.
    drive(1, 1, 2, 4, 8'h11, 8'hFF);
    n_vec++;
    if ({rsp_valid, occupancy, full} !== {1'b0, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL flush: got %h want %h", {rsp_valid, occupancy, full}, {1'b0, 5'd0, 1'b0});
    end
    $display("flush: occ=%0d full=%0d", occupancy, full);
    snap = model_vec();
    n_vec++;
    if (obs_vec !== snap) begin
      n_bad++; $display("FAIL directed_model: got %h want %h", obs_vec, snap);
    end
  endtask

  task automatic test_full_ena_reset();
    logic [17:0] snap;
    for (int i = 0; i < DP; i++) drive(1, 0, 2, i, 8'(8'h80 + i), 8'hFF);
    n_vec++;
    if ({occupancy, full} !== {5'd16, 1'b1}) begin
      n_bad++; $display("FAIL fill_full: got %h want %h", {occupancy, full}, {5'd16, 1'b1});
    end
    drive(1, 0, 1, 0, 8'h80, 8'h00);
    n_vec++;
    if ({hit, multi_hit, hit_addr, hit_count} !== {2'b11, 4'd0, 5'd16}) begin
      n_bad++; $display("FAIL mask0_all: got %h want %h", {hit, multi_hit, hit_addr, hit_count}, {2'b11, 4'd0, 5'd16});
    end
    snap = obs_vec;
    drive(0, 0, 2, 0, 8'h00, 8'hFF);
    drive(0, 1, 1, 0, 8'h00, 8'hFF);
    n_vec++;
    if (obs_vec !== {1'b0, snap[16:0]}) begin
      n_bad++; $display("FAIL ena_hold: got %h want %h", obs_vec, {1'b0, snap[16:0]});
    end
    drive(1, 0, 1, 0, 8'h00, 8'hFF);
    n_vec++;
    if ({rsp_valid, hit, occupancy} !== {2'b10, 5'd16}) begin
      n_bad++; $display("FAIL ena_no_write: got %h want %h", {rsp_valid, hit, occupancy}, {2'b10, 5'd16});
    end
    $display("full: occ=%0d full=%0d", occupancy, full);
    // Reset asserted while a search result is live, mid-cycle.
    drive(1, 0, 1, 0, 8'h8F, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_vec !== 18'h0) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", obs_vec, 18'h0);
    end
    model_reset();
    $display("async reset: outputs %h", obs_vec);
    @(negedge clk); rst_n = 1'b1; ena = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] masks [5];
    masks[0] = 8'hFF; masks[1] = 8'hF0; masks[2] = 8'h0F; masks[3] = 8'h00; masks[4] = 8'hFF;
    for (int t = 0; t < 600; t++) begin
      int r = $urandom_range(0, 99);
      bit e = ($urandom_range(0, 9) != 0);
      bit f = (r < 3);
      int o = (r < 40) ? 2 : (r < 80) ? 1 : (r < 92) ? 3 : 0;
      int a = $urandom_range(0, DP - 1);
      logic [7:0] d = ($urandom_range(0, 1) != 0) ? 8'(8'h50 | 8'($urandom_range(0, 15)))
                                                 : 8'($urandom_range(0, 255));
      logic [7:0] m = masks[$urandom_range(0, 4)];
      logic [17:0] want;
      if ($urandom_range(0, 4) == 0) m = 8'($urandom_range(0, 255));
      drive(e, f, o, a, d, m);
      want = model_vec();
      n_vec++;
      if (obs_vec !== want) begin
        n_bad++; $display("FAIL random_%0d: got %h want %h (e=%0d f=%0d op=%0d a=%0d d=%h m=%h)",
                          t, obs_vec, want, e, f, o, a, d, m);
      end else if (rsp_valid) begin
        $display("rand %0d: search d=%h m=%h hit=%0d addr=%0d cnt=%0d occ=%0d", t, d, m, hit, hit_addr, hit_count, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full_ena_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
